// File: rtl/mem_video__reader_pkg.sv
// Shared definitions for the DDR video line reader/writer pair: MCB opcodes,
// pixel stride, FSM state type and the width helper.
package mem_video__reader_pkg;

  localparam logic [2:0] MCB_CMD_READ  = 3'b001;
  localparam logic [2:0] MCB_CMD_WRITE = 3'b000;
  localparam int         PIX_BYTES     = 4;

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} rd_state_e;

  // Number of bits needed to hold the value x (never less than 1).
  function automatic int ceil_log2(input int x);
    int n;
    n = 1;
    while ((x >> n) != 0) n++;
    return n;
  endfunction

endpackage

// File: rtl/mem_video__reader_if.sv
// MCB-style user port: command channel plus read-data FIFO and calibration flag.
interface mem_video__reader_if;
  logic        mem_calib_done;
  logic        mem_cmd_full;
  logic        mem_cmd_en;
  logic [2:0]  mem_cmd_instr;
  logic [5:0]  mem_cmd_bl;
  logic [29:0] mem_cmd_byte_addr;
  logic        mem_rd_empty;
  logic        mem_rd_en;
  logic [31:0] mem_rd_data;

  modport master (
    input  mem_calib_done, mem_cmd_full, mem_rd_empty, mem_rd_data,
    output mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en
  );

  modport slave (
    output mem_calib_done, mem_cmd_full, mem_rd_empty, mem_rd_data,
    input  mem_cmd_en, mem_cmd_instr, mem_cmd_bl, mem_cmd_byte_addr, mem_rd_en
  );
endinterface

// File: rtl/mem_video__reader_line_buffer.sv
// Simple dual-port line RAM: write port fed by FIFO pops, registered read port
// for the consumer. Storage has no reset so it maps onto block RAM.
module line_buffer_1r1w #(
  parameter int DEPTH = 640,
  parameter int AW    = 10,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else        rdata <= mem[raddr];
endmodule

// File: rtl/mem_video__reader.sv
// Fetches one video line from DDR in bursts of up to BURST_WORDS words and
// lands the pixels in an on-chip line buffer with a random-access read port.
module mem_video__reader
  import mem_video__reader_pkg::*;
#(
  parameter int          H_RES_PIX   = 640,
  parameter int          V_RES_PIX   = 480,
  parameter logic [29:0] BASE_ADDR   = 30'd0,
  parameter int          BURST_WORDS = 64,
  parameter int          H_ADDR_BITS = ceil_log2(H_RES_PIX - 1),
  parameter int          V_ADDR_BITS = ceil_log2(V_RES_PIX - 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   line_req,
  input  logic [V_ADDR_BITS-1:0] line_num,
  output logic                   busy,
  output logic                   line_done,
  output logic                   req_err,
  input  logic [H_ADDR_BITS-1:0] rd_addr,
  output logic [23:0]            rd_data,
  mem_video__reader_if.master    mcb
);
  // word_idx must be able to reach H_RES_PIX itself, hence one more value than the buffer address
  localparam int               CNT_W      = ceil_log2(H_RES_PIX);
  localparam logic [29:0]      LINE_BYTES = 30'(PIX_BYTES * H_RES_PIX);
  localparam logic [CNT_W-1:0] H_END      = CNT_W'(H_RES_PIX);
  localparam logic [6:0]       BURST_MAX  = 7'(BURST_WORDS);

  rd_state_e        state, state_nxt;
  logic [29:0]      line_addr;
  logic [CNT_W-1:0] word_idx, remain;
  logic [6:0]       burst_cnt, burst_n;
  logic             accept, pop;

  assign accept  = (state == S_IDLE) && line_req && mcb.mem_calib_done
                   && (int'(line_num) < V_RES_PIX);
  assign pop     = (state == S_DATA) && !mcb.mem_rd_empty;
  assign remain  = H_END - word_idx;
  assign burst_n = (int'(remain) < BURST_WORDS) ? 7'(remain) : BURST_MAX;

  assign mcb.mem_cmd_instr = MCB_CMD_READ;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt             = state;
    busy                  = 1'b0;
    line_done             = 1'b0;
    mcb.mem_cmd_en        = 1'b0;
    mcb.mem_cmd_bl        = '0;
    mcb.mem_cmd_byte_addr = '0;
    mcb.mem_rd_en         = 1'b0;
    unique case (state)
      S_IDLE: if (accept) state_nxt = S_CMD;
      S_CMD: begin
        busy                  = 1'b1;
        mcb.mem_cmd_bl        = 6'(burst_n - 7'd1);
        mcb.mem_cmd_byte_addr = line_addr + 30'(word_idx) * 30'(PIX_BYTES);
        if (!mcb.mem_cmd_full) begin
          mcb.mem_cmd_en = 1'b1;
          state_nxt      = S_DATA;
        end
      end
      S_DATA: begin
        busy          = 1'b1;
        mcb.mem_rd_en = !mcb.mem_rd_empty;
        if (pop && burst_cnt == 7'd1)
          state_nxt = (word_idx + CNT_W'(1) == H_END) ? S_DONE : S_CMD;
      end
      S_DONE: begin
        line_done = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Any request that is not accepted (busy, bad line, uncalibrated) is flagged next cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      line_addr <= '0;
      word_idx  <= '0;
      burst_cnt <= '0;
      req_err   <= 1'b0;
    end else begin
      req_err <= line_req && !accept;
      if (accept) begin
        line_addr <= BASE_ADDR + LINE_BYTES * 30'(line_num);
        word_idx  <= '0;
      end
      if (mcb.mem_cmd_en) burst_cnt <= burst_n;
      if (pop) begin
        word_idx  <= word_idx + CNT_W'(1);
        burst_cnt <= burst_cnt - 7'd1;
      end
    end

  line_buffer_1r1w #(
    .DEPTH(H_RES_PIX),
    .AW   (H_ADDR_BITS),
    .DW   (24)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (pop),
    .waddr(H_ADDR_BITS'(word_idx)),
    .wdata(mcb.mem_rd_data[23:0]),
    .raddr(rd_addr),
    .rdata(rd_data)
  );
endmodule

// File: tb/tb_mem_video__reader.sv
// Directed bench: a 640-pixel reader driven from a vector table plus corner
// sequences, and a 650-pixel reader for the short final burst.
module tb_mem_video__reader;
  import mem_video__reader_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  mem_video__reader_if m1();
  mem_video__reader_if m2();

  logic       line_req = 1'b0, line_req2 = 1'b0;
  logic [8:0] line_num = '0, line_num2 = '0;
  logic [9:0] rd_addr = '0, rd_addr2 = '0;
  logic       busy, line_done, req_err, busy2, done2, err2;
  logic [23:0] rd_data, rd_data2;
  logic       calib = 1'b1, full1 = 1'b0, bub_en = 1'b0, mon_clr = 1'b0;

  mem_video__reader dut (
    .clk(clk), .rst_n(rst_n), .line_req(line_req), .line_num(line_num),
    .busy(busy), .line_done(line_done), .req_err(req_err),
    .rd_addr(rd_addr), .rd_data(rd_data), .mcb(m1)
  );

  mem_video__reader #(.H_RES_PIX(650), .BASE_ADDR(30'h100)) dut2 (
    .clk(clk), .rst_n(rst_n), .line_req(line_req2), .line_num(line_num2),
    .busy(busy2), .line_done(done2), .req_err(err2),
    .rd_addr(rd_addr2), .rd_data(rd_data2), .mcb(m2)
  );

  function automatic logic [23:0] pix(input logic [29:0] a);
    return a[25:2] ^ 24'hC35A96;
  endfunction

  // DDR model: one outstanding burst, sequential words from the command address
  logic [29:0] p_addr, p2_addr;
  int          p_cnt, p2_cnt;
  logic        bub;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p_addr <= '0; p_cnt <= 0; bub <= 1'b0;
      p2_addr <= '0; p2_cnt <= 0;
    end else begin
      bub <= bub_en && ($urandom_range(0, 2) == 0);
      if (m1.mem_cmd_en) begin
        p_addr <= m1.mem_cmd_byte_addr; p_cnt <= int'(m1.mem_cmd_bl) + 1;
      end else if (m1.mem_rd_en && !m1.mem_rd_empty) begin
        p_addr <= p_addr + 30'd4; p_cnt <= p_cnt - 1;
      end
      if (m2.mem_cmd_en) begin
        p2_addr <= m2.mem_cmd_byte_addr; p2_cnt <= int'(m2.mem_cmd_bl) + 1;
      end else if (m2.mem_rd_en && !m2.mem_rd_empty) begin
        p2_addr <= p2_addr + 30'd4; p2_cnt <= p2_cnt - 1;
      end
    end

  assign m1.mem_calib_done = calib;
  assign m1.mem_cmd_full   = full1;
  assign m1.mem_rd_empty   = (p_cnt == 0) || bub;
  assign m1.mem_rd_data    = {8'hEE, pix(p_addr)};
  assign m2.mem_calib_done = 1'b1;
  assign m2.mem_cmd_full   = 1'b0;
  assign m2.mem_rd_empty   = (p2_cnt == 0);
  assign m2.mem_rd_data    = {8'hEE, pix(p2_addr)};

  // Bus monitor
  int cyc = 0;
  int ncmd, npop, viol, last_pop, done_cyc;
  int ncmd2, npop2, last_pop2, done_cyc2;
  logic [29:0] cmd_addr [16];
  logic [5:0]  cmd_bl [16];
  logic [29:0] first_addr2, last_addr2;
  logic [5:0]  last_bl2;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mon_clr) begin
      ncmd <= 0; npop <= 0; viol <= 0; ncmd2 <= 0; npop2 <= 0;
    end else begin
      viol <= viol + int'(m1.mem_cmd_en && m1.mem_cmd_full)
                   + int'(m1.mem_rd_en && m1.mem_rd_empty);
      if (m1.mem_cmd_en) begin
        if (ncmd < 16) begin
          cmd_addr[ncmd[3:0]] <= m1.mem_cmd_byte_addr;
          cmd_bl[ncmd[3:0]]   <= m1.mem_cmd_bl;
        end
        ncmd <= ncmd + 1;
      end
      if (m1.mem_rd_en && !m1.mem_rd_empty) begin npop <= npop + 1; last_pop <= cyc; end
      if (line_done) done_cyc <= cyc;
      if (m2.mem_cmd_en) begin
        if (ncmd2 == 0) first_addr2 <= m2.mem_cmd_byte_addr;
        last_addr2 <= m2.mem_cmd_byte_addr; last_bl2 <= m2.mem_cmd_bl;
        ncmd2 <= ncmd2 + 1;
      end
      if (m2.mem_rd_en && !m2.mem_rd_empty) begin npop2 <= npop2 + 1; last_pop2 <= cyc; end
      if (done2) done_cyc2 <= cyc;
    end
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    mon_clr = 1'b1; tick(); mon_clr = 1'b0;
  endtask

  task automatic request(input logic [8:0] ln, input logic cal);
    line_num = ln; calib = cal; line_req = 1'b1; tick(); line_req = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int n = 0;
    while (!line_done && n < bound) begin tick(); n++; end
    check({nm, "_done"}, 64'(line_done), 64'd1);
    check({nm, "_busy_fall"}, 64'(busy), 64'd0);
    tick();
  endtask

  task automatic read_buf(input logic [29:0] base, output int bad);
    bad = 0;
    for (int k = 0; k < 640; k++) begin
      rd_addr = 10'(k); tick();
      if (rd_data !== pix(base + 30'(4 * k))) bad++;
    end
  endtask

  task automatic check_fetch(input string nm, input logic [29:0] base);
    int bad;
    check({nm, "_ncmd"}, 64'(ncmd), 64'd10);
    for (int c = 0; c < 10; c++) begin
      check({nm, "_cmd_addr"}, 64'(cmd_addr[c]), 64'(base + 30'(256 * c)));
      check({nm, "_cmd_bl"}, 64'(cmd_bl[c]), 64'd63);
    end
    check({nm, "_npop"}, 64'(npop), 64'd640);
    check({nm, "_done_lat"}, 64'(done_cyc - last_pop), 64'd1);
    check({nm, "_blocked_xfer"}, 64'(viol), 64'd0);
    read_buf(base, bad);
    check({nm, "_buf_mismatches"}, 64'(bad), 64'd0);
  endtask

  typedef struct {
    logic [8:0]  ln;
    logic        cal;
    logic        bubbles;
    logic        exp_err;
    logic [29:0] exp_base;
  } vec_t;
  vec_t vt[5];

  initial begin
    int n;
    vt[0] = '{9'd3,   1'b1, 1'b0, 1'b0, 30'h1E00};
    vt[1] = '{9'd480, 1'b1, 1'b0, 1'b1, 30'h0};
    vt[2] = '{9'd5,   1'b0, 1'b0, 1'b1, 30'h0};
    vt[3] = '{9'd479, 1'b1, 1'b1, 1'b0, 30'h12B600};
    vt[4] = '{9'd0,   1'b1, 1'b1, 1'b0, 30'h0};

    repeat (3) tick();
    check("reset_state", 64'({busy, line_done, req_err, m1.mem_cmd_en, m1.mem_rd_en,
                              m1.mem_cmd_bl, m1.mem_cmd_byte_addr, rd_data}), 64'd0);
    check("cmd_instr", 64'(m1.mem_cmd_instr), 64'd1);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      clr();
      bub_en = vt[i].bubbles;
      request(vt[i].ln, vt[i].cal);
      check("req_err", 64'(req_err), 64'(vt[i].exp_err));
      check("busy_rise", 64'(busy), 64'(!vt[i].exp_err));
      if (vt[i].exp_err) begin
        repeat (4) tick();
        check("rejected_no_cmd", 64'(ncmd), 64'd0);
        check("rejected_idle", 64'(busy), 64'd0);
      end else begin
        wait_done("vec", 3000);
        check_fetch("vec", vt[i].exp_base);
      end
      calib = 1'b1;
    end

    // Command FIFO full for 5 cycles, with read-FIFO bubbles
    clr();
    full1 = 1'b1; bub_en = 1'b1;
    request(9'd9, 1'b1);
    repeat (5) tick();
    check("full_no_cmd", 64'(ncmd), 64'd0);
    check("full_busy", 64'(busy), 64'd1);
    full1 = 1'b0;
    wait_done("full", 3000);
    check_fetch("full", 30'(9 * 2560));

    // Requests while busy, and calibration dropping mid-fetch
    clr();
    bub_en = 1'b0;
    request(9'd4, 1'b1);
    repeat (20) tick();
    line_num = 9'd9; line_req = 1'b1; tick(); line_req = 1'b0;
    check("busy_req_err", 64'(req_err), 64'd1);
    check("busy_still", 64'(busy), 64'd1);
    tick();
    check("req_err_pulse", 64'(req_err), 64'd0);
    line_num = 9'd480; line_req = 1'b1; tick(); line_req = 1'b0;
    check("busy_badline_err", 64'(req_err), 64'd1);
    calib = 1'b0;
    wait_done("busy", 3000);
    calib = 1'b1;
    check_fetch("busy", 30'(4 * 2560));

    // Reset in the middle of the 4th burst
    clr();
    request(9'd6, 1'b1);
    n = 0;
    while (npop < 202 && n < 2000) begin tick(); n++; end
    check("mid_ncmd", 64'(ncmd), 64'd4);
    rst_n = 1'b0; #1;
    check("mid_reset_outs", 64'({busy, line_done, req_err, m1.mem_cmd_en, m1.mem_rd_en,
                                 m1.mem_cmd_bl, m1.mem_cmd_byte_addr, rd_data}), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    clr();
    request(9'd2, 1'b1);
    wait_done("after_rst", 3000);
    check_fetch("after_rst", 30'h1400);

    // 650-pixel line: short final burst
    clr();
    line_num2 = 9'd1; line_req2 = 1'b1; tick(); line_req2 = 1'b0;
    check("h650_busy", 64'(busy2), 64'd1);
    n = 0;
    while (!done2 && n < 3000) begin tick(); n++; end
    check("h650_done", 64'(done2), 64'd1);
    tick();
    check("h650_ncmd", 64'(ncmd2), 64'd11);
    check("h650_first_addr", 64'(first_addr2), 64'h100 + 64'd2600);
    check("h650_last_bl", 64'(last_bl2), 64'd9);
    check("h650_last_addr", 64'(last_addr2), 64'h100 + 64'd2600 + 64'd2560);
    check("h650_npop", 64'(npop2), 64'd650);
    check("h650_done_lat", 64'(done_cyc2 - last_pop2), 64'd1);
    rd_addr2 = 10'd649; tick();
    check("h650_last_pix", 64'(rd_data2), 64'(pix(30'h100 + 30'd2600 + 30'd2596)));
    rd_addr2 = 10'd640; tick();
    check("h650_pix640", 64'(rd_data2), 64'(pix(30'h100 + 30'd2600 + 30'd2560)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
